// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Purpose  : Pre-decode next-PC predictor. Direct branches (b/bl/cond) get
//            their target from the instruction offset; conditionals consult
//            a gshare PHT; returns pop a return-address stack; other jirl
//            use a fully-associative BTB. Speculative GHR/RAS advance on
//            accepted lookups and are restored from committed copies (which
//            follow retiring branches) on flush.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            lkp_valid/pc/inst/accept - pre-decode lookup and its acceptance
//            pred_taken/target/src    - combinational prediction
//                                       (src: 0 none, 1 offset, 2 RAS, 3 BTB)
//            upd_valid/pc/inst/taken/target - retiring branch at writeback
//            flush                    - restore speculative state
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
  parameter int BTB_ENTRIES = 16,
  parameter int BTB_TAG_WID = 12,
  parameter int GHR_WID     = 10,
  parameter int RAS_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lkp_valid,
  input  logic [31:0] lkp_pc,
  input  logic [31:0] lkp_inst,
  input  logic        lkp_accept,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [1:0]  pred_src,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_inst,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush
);

  localparam int PHT_ENTRIES = 1 << GHR_WID;
  localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int RAS_PTR_W   = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W   = RAS_PTR_W + 1;

  localparam logic [RAS_CNT_W-1:0] RAS_FULL = RAS_CNT_W'(RAS_DEPTH);
  localparam logic [RAS_CNT_W-1:0] CNT_ONE  = RAS_CNT_W'(1);
  localparam logic [RAS_PTR_W-1:0] PTR_ONE  = RAS_PTR_W'(1);
  localparam logic [BTB_IDX_W-1:0] RR_ONE   = BTB_IDX_W'(1);

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BGEU = 6'h1b;

  // ptr is the next write slot; the top of stack lives at ptr-1.
  typedef struct packed {
    logic [RAS_DEPTH-1:0][31:0] ent;
    logic [RAS_PTR_W-1:0]       ptr;
    logic [RAS_CNT_W-1:0]       cnt;
  } ras_t;

  function automatic logic is_jirl(input logic [31:0] inst);
    return inst[31:26] == OP_JIRL;
  endfunction

  function automatic logic is_direct(input logic [31:0] inst);
    return (inst[31:26] == OP_B) || (inst[31:26] == OP_BL);
  endfunction

  function automatic logic is_cond(input logic [31:0] inst);
    return (inst[31:26] >= OP_BEQ) && (inst[31:26] <= OP_BGEU);
  endfunction

  function automatic logic is_call(input logic [31:0] inst);
    return (inst[31:26] == OP_BL) || (is_jirl(inst) && inst[4:0] == 5'd1);
  endfunction

  function automatic logic is_ret(input logic [31:0] inst);
    return is_jirl(inst) && inst[4:0] == 5'd0 && inst[9:5] == 5'd1;
  endfunction

  // jirl rd=1,rj=1 is a coroutine switch: it pops and pushes together.
  function automatic logic ras_pop_op(input logic [31:0] inst);
    return is_jirl(inst) && inst[9:5] == 5'd1 && inst[4:1] == 4'd0;
  endfunction

  function automatic logic [31:0] offs26(input logic [31:0] inst);
    return {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  endfunction

  function automatic logic [31:0] offs16(input logic [31:0] inst);
    return {{14{inst[25]}}, inst[25:10], 2'b00};
  endfunction

  function automatic ras_t ras_step(input ras_t cur, input logic pop,
                                    input logic push, input logic [31:0] val);
    ras_t                 nxt;
    logic [RAS_PTR_W-1:0] top;
    nxt = cur;
    top = cur.ptr - PTR_ONE;
    if (pop && (cur.cnt != '0)) begin
      if (push) begin
        nxt.ent[top] = val;                 // pop+push collapses to replace-top
      end else begin
        nxt.ptr = top;
        nxt.cnt = cur.cnt - CNT_ONE;
      end
    end else if (push) begin
      nxt.ent[cur.ptr] = val;               // overwrites the oldest when full
      nxt.ptr          = cur.ptr + PTR_ONE;
      if (cur.cnt != RAS_FULL) nxt.cnt = cur.cnt + CNT_ONE;
    end
    return nxt;
  endfunction

  // State
  logic [1:0]             pht_q [PHT_ENTRIES];
  logic [GHR_WID-1:0]     spec_ghr_q, spec_ghr_d;
  logic [GHR_WID-1:0]     cmt_ghr_q, cmt_ghr_d;
  ras_t                   spec_ras_q, spec_ras_d;
  ras_t                   cmt_ras_q, cmt_ras_d;
  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [BTB_TAG_WID-1:0] btb_tag_q [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [BTB_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Lookup side
  logic [GHR_WID-1:0]     lkp_idx;
  logic                   lkp_pht_taken;
  logic [BTB_TAG_WID-1:0] lkp_tag;
  logic                   lkp_btb_hit;
  logic [31:0]            lkp_btb_tgt;
  logic [RAS_PTR_W-1:0]   spec_top;

  // Update side
  logic [GHR_WID-1:0]     upd_idx;
  logic [1:0]             upd_ctr;
  logic                   pht_we;
  logic [1:0]             pht_wdata;
  logic [BTB_TAG_WID-1:0] upd_tag;
  logic                   upd_btb_hit;
  logic [BTB_IDX_W-1:0]   upd_hit_idx;
  logic                   btb_we;
  logic [BTB_IDX_W-1:0]   btb_widx;

  // Offset bits of retiring instructions are not needed: the actual target
  // arrives on upd_target.
  logic unused_ok;
  assign unused_ok = ^upd_inst[25:10];

  always_comb begin
    lkp_idx       = spec_ghr_q ^ lkp_pc[GHR_WID+1:2];
    lkp_pht_taken = pht_q[lkp_idx][1];
    lkp_tag       = lkp_pc[BTB_TAG_WID+1:2];
    spec_top      = spec_ras_q.ptr - PTR_ONE;
    lkp_btb_hit   = 1'b0;
    lkp_btb_tgt   = '0;
    // At most one entry can match, so OR-ing the targets is a valid mux.
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (btb_valid_q[i] && btb_tag_q[i] == lkp_tag) begin
        lkp_btb_hit = 1'b1;
        lkp_btb_tgt = lkp_btb_tgt | btb_tgt_q[i];
      end
    end
  end

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    pred_src    = 2'd0;
    if (lkp_valid) begin
      if (is_direct(lkp_inst)) begin
        pred_taken  = 1'b1;
        pred_target = lkp_pc + offs26(lkp_inst);
        pred_src    = 2'd1;
      end else if (is_cond(lkp_inst)) begin
        if (lkp_pht_taken) begin
          pred_taken  = 1'b1;
          pred_target = lkp_pc + offs16(lkp_inst);
          pred_src    = 2'd1;
        end
      end else if (is_ret(lkp_inst) && spec_ras_q.cnt != '0) begin
        pred_taken  = 1'b1;
        pred_target = spec_ras_q.ent[spec_top];
        pred_src    = 2'd2;
      end else if (is_jirl(lkp_inst) && lkp_btb_hit) begin
        pred_taken  = 1'b1;
        pred_target = lkp_btb_tgt;
        pred_src    = 2'd3;
      end
    end
  end

  // Committed state: PHT training uses the history before this branch shifts in.
  always_comb begin
    upd_idx   = cmt_ghr_q ^ upd_pc[GHR_WID+1:2];
    upd_ctr   = pht_q[upd_idx];
    pht_we    = upd_valid && is_cond(upd_inst);
    pht_wdata = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != 2'b11) pht_wdata = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) pht_wdata = upd_ctr - 2'b01;
    end
    cmt_ghr_d = pht_we ? {cmt_ghr_q[GHR_WID-2:0], upd_taken} : cmt_ghr_q;
    cmt_ras_d = upd_valid ? ras_step(cmt_ras_q, ras_pop_op(upd_inst),
                                     is_call(upd_inst), upd_pc + 32'd4)
                          : cmt_ras_q;

    upd_tag     = upd_pc[BTB_TAG_WID+1:2];
    upd_btb_hit = 1'b0;
    upd_hit_idx = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (btb_valid_q[i] && btb_tag_q[i] == upd_tag) begin
        upd_btb_hit = 1'b1;
        upd_hit_idx = BTB_IDX_W'(i);
      end
    end
    btb_we   = upd_valid && is_jirl(upd_inst) && !is_ret(upd_inst) && upd_taken;
    btb_widx = upd_btb_hit ? upd_hit_idx : rr_ptr_q;
    rr_ptr_d = (btb_we && !upd_btb_hit) ? rr_ptr_q + RR_ONE : rr_ptr_q;
  end

  // Speculative state: flush restores from the post-update committed copy
  // and wins over any accepted lookup in the same cycle.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    spec_ras_d = spec_ras_q;
    if (flush) begin
      spec_ghr_d = cmt_ghr_d;
      spec_ras_d = cmt_ras_d;
    end else if (lkp_valid && lkp_accept) begin
      if (is_cond(lkp_inst)) spec_ghr_d = {spec_ghr_q[GHR_WID-2:0], lkp_pht_taken};
      spec_ras_d = ras_step(spec_ras_q, ras_pop_op(lkp_inst),
                            is_call(lkp_inst), lkp_pc + 32'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr_q  <= '0;
      cmt_ghr_q   <= '0;
      spec_ras_q  <= '0;
      cmt_ras_q   <= '0;
      btb_valid_q <= '0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      cmt_ghr_q  <= cmt_ghr_d;
      spec_ras_q <= spec_ras_d;
      cmt_ras_q  <= cmt_ras_d;
      rr_ptr_q   <= rr_ptr_d;
      if (pht_we) pht_q[upd_idx] <= pht_wdata;
      if (btb_we) begin
        btb_valid_q[btb_widx] <= 1'b1;
        btb_tag_q[btb_widx]   <= upd_tag;
        btb_tgt_q[btb_widx]   <= upd_target;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_unit
// Purpose  : Self-checking bench for branch_predict_unit. A queue/array model
//            predicts every cycle; directed steps also carry literal
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  localparam int BTB_ENTRIES = 16;
  localparam int BTB_TAG_WID = 12;
  localparam int GHR_WID     = 10;
  localparam int RAS_DEPTH   = 8;
  localparam int PHT_N       = 1 << GHR_WID;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lkp_valid, lkp_accept, upd_valid, upd_taken, flush;
  logic [31:0] lkp_pc, lkp_inst, upd_pc, upd_inst, upd_target;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_src;

  branch_predict_unit #(
    .BTB_ENTRIES(BTB_ENTRIES), .BTB_TAG_WID(BTB_TAG_WID),
    .GHR_WID(GHR_WID), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .lkp_valid(lkp_valid), .lkp_pc(lkp_pc), .lkp_inst(lkp_inst), .lkp_accept(lkp_accept),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_src(pred_src),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_inst(upd_inst),
    .upd_taken(upd_taken), .upd_target(upd_target), .flush(flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  typedef logic [31:0] q32_t[$];
  int                     m_pht [PHT_N];
  logic [GHR_WID-1:0]     m_sghr, m_cghr;
  q32_t                   m_sras, m_cras;
  bit                     m_bv   [BTB_ENTRIES];
  logic [BTB_TAG_WID-1:0] m_btag [BTB_ENTRIES];
  logic [31:0]            m_btgt [BTB_ENTRIES];
  int                     m_rr;

  function automatic bit m_cond(input logic [31:0] inst);
    return inst[31:26] >= 6'h16 && inst[31:26] <= 6'h1b;
  endfunction

  function automatic bit m_ret(input logic [31:0] inst);
    return inst[31:26] == OP_JIRL && inst[4:0] == 5'd0 && inst[9:5] == 5'd1;
  endfunction

  function automatic q32_t ras_apply(input q32_t q, input logic [31:0] inst,
                                     input logic [31:0] pc);
    q32_t r;
    bit   jirl, pop, push;
    r    = q;
    jirl = inst[31:26] == OP_JIRL;
    pop  = jirl && inst[9:5] == 5'd1 && inst[4:0] <= 5'd1;
    push = inst[31:26] == OP_BL || (jirl && inst[4:0] == 5'd1);
    if (pop && r.size() > 0) void'(r.pop_back());
    if (push) begin
      r.push_back(pc + 32'd4);
      if (r.size() > RAS_DEPTH) void'(r.pop_front());
    end
    return r;
  endfunction

  function automatic void model_pred(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                     output logic tk, output logic [31:0] tg, output logic [1:0] src);
    int          idx, o;
    logic [25:0] w26;
    logic [15:0] w16;
    tk = 1'b0; tg = '0; src = 2'd0;
    if (v) begin
      w26 = {inst[9:0], inst[25:10]};
      w16 = inst[25:10];
      if (inst[31:26] == OP_B || inst[31:26] == OP_BL) begin
        o = $signed(w26);
        tk = 1'b1; tg = pc + 32'(o * 4); src = 2'd1;
      end else if (m_cond(inst)) begin
        idx = int'(m_sghr ^ pc[GHR_WID+1:2]);
        if (m_pht[idx] >= 2) begin
          o = $signed(w16);
          tk = 1'b1; tg = pc + 32'(o * 4); src = 2'd1;
        end
      end else if (inst[31:26] == OP_JIRL) begin
        if (m_ret(inst) && m_sras.size() > 0) begin
          tk = 1'b1; tg = m_sras[$]; src = 2'd2;
        end else begin
          for (int i = 0; i < BTB_ENTRIES; i++)
            if (m_bv[i] && m_btag[i] == pc[BTB_TAG_WID+1:2]) begin
              tk = 1'b1; tg = m_btgt[i]; src = 2'd3;
            end
        end
      end
    end
  endfunction

  always @(posedge clk) begin : model_upd
    logic        ptk;
    logic [31:0] ptg;
    logic [1:0]  psrc;
    int          idx;
    bit          hit;
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
      for (int i = 0; i < BTB_ENTRIES; i++) m_bv[i] = 1'b0;
      m_sghr = '0; m_cghr = '0; m_rr = 0;
      m_sras.delete(); m_cras.delete();
    end else begin
      model_pred(lkp_valid, lkp_pc, lkp_inst, ptk, ptg, psrc);
      if (upd_valid) begin
        if (m_cond(upd_inst)) begin
          idx = int'(m_cghr ^ upd_pc[GHR_WID+1:2]);
          if (upd_taken) m_pht[idx] = (m_pht[idx] < 3) ? m_pht[idx] + 1 : 3;
          else           m_pht[idx] = (m_pht[idx] > 0) ? m_pht[idx] - 1 : 0;
          m_cghr = {m_cghr[GHR_WID-2:0], upd_taken};
        end
        if (upd_inst[31:26] == OP_JIRL && !m_ret(upd_inst) && upd_taken) begin
          hit = 1'b0;
          for (int i = 0; i < BTB_ENTRIES; i++)
            if (m_bv[i] && m_btag[i] == upd_pc[BTB_TAG_WID+1:2]) begin
              m_btgt[i] = upd_target; hit = 1'b1;
            end
          if (!hit) begin
            m_bv[m_rr] = 1'b1; m_btag[m_rr] = upd_pc[BTB_TAG_WID+1:2];
            m_btgt[m_rr] = upd_target; m_rr = (m_rr + 1) % BTB_ENTRIES;
          end
        end
        m_cras = ras_apply(m_cras, upd_inst, upd_pc);
      end
      if (flush) begin
        m_sghr = m_cghr;
        m_sras = m_cras;
      end else if (lkp_valid && lkp_accept) begin
        if (m_cond(lkp_inst)) m_sghr = {m_sghr[GHR_WID-2:0], ptk};
        m_sras = ras_apply(m_sras, lkp_inst, lkp_pc);
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin : compare
    logic        etk;
    logic [31:0] etg;
    logic [1:0]  esrc;
    if (!rst) begin
      model_pred(lkp_valid, lkp_pc, lkp_inst, etk, etg, esrc);
      checks++;
      if (pred_taken !== etk || pred_target !== etg || pred_src !== esrc) begin
        errors++;
        $display("FAIL model_cmp t=%0t pc=%h inst=%h got tk=%0b tgt=%h src=%0d want tk=%0b tgt=%h src=%0d",
                 $time, lkp_pc, lkp_inst, pred_taken, pred_target, pred_src, etk, etg, esrc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk26(input logic [5:0] op, input int offs);
    logic [25:0] w;
    w = 26'(offs >>> 2);
    return {op, w[15:0], w[25:16]};
  endfunction

  function automatic logic [31:0] mk16(input logic [5:0] op, input int offs,
                                       input logic [4:0] rj, input logic [4:0] rd);
    logic [15:0] w;
    w = 16'(offs >>> 2);
    return {op, w, rj, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    lkp_valid = 0; lkp_pc = 0; lkp_inst = 0; lkp_accept = 0;
    upd_valid = 0; upd_pc = 0; upd_inst = 0; upd_taken = 0; upd_target = 0;
    flush = 0;
  endtask

  task automatic look(input logic [31:0] pc, input logic [31:0] inst, input logic acc);
    lkp_valid = 1'b1; lkp_pc = pc; lkp_inst = inst; lkp_accept = acc;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] inst,
                        input logic tk, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_inst = inst; upd_taken = tk; upd_target = tgt;
  endtask

  task automatic lit(input string nm, input logic etk, input logic [31:0] etg, input logic [1:0] esrc);
    #2;
    checks++;
    if (pred_taken !== etk || pred_target !== etg || pred_src !== esrc) begin
      errors++;
      $display("FAIL %s: got tk=%0b tgt=%h src=%0d want tk=%0b tgt=%h src=%0d",
               nm, pred_taken, pred_target, pred_src, etk, etg, esrc);
    end
  endtask

  logic [31:0] beq_f, beq_b, ret_i, jr5;

  initial begin
    beq_f = mk16(OP_BEQ, 32'sh20, 5'd4, 5'd5);
    beq_b = mk16(OP_BEQ, -256, 5'd4, 5'd5);
    ret_i = mk16(OP_JIRL, 0, 5'd1, 5'd0);
    jr5   = mk16(OP_JIRL, 0, 5'd5, 5'd0);
    clr();
    rst = 1'b1;
    tick(); tick();
    lit("reset_idle", 1'b0, 32'h0, 2'd0);
    tick();
    rst = 1'b0;

    // Direct targets and a cold conditional
    look(32'h1c000000, mk26(OP_B, 32'sh40), 1'b0); lit("b_fwd", 1'b1, 32'h1c000040, 2'd1); tick();
    look(32'h1c000000, mk26(OP_B, -8), 1'b0);      lit("b_back", 1'b1, 32'h1bfffff8, 2'd1); tick();
    look(32'h1c000000, beq_f, 1'b0);               lit("beq_weak_nt", 1'b0, 32'h0, 2'd0); tick();
    clr();

    // Train PHT entry 0x40 to 11 (history 0 then 1), then look it up
    retire(32'h1c000100, beq_f, 1'b1, 32'h1c000120); tick();
    retire(32'h1c000104, beq_f, 1'b1, 32'h1c000124); tick();
    clr(); flush = 1'b1; tick(); clr();
    look(32'h1c00010c, beq_f, 1'b0); lit("beq_trained", 1'b1, 32'h1c00012c, 2'd1); tick();
    clr();
    retire(32'h1c00010c, beq_f, 1'b0, 32'h0); tick();
    clr(); flush = 1'b1; tick(); clr();
    look(32'h1c000118, beq_b, 1'b1); lit("beq_back_sat", 1'b1, 32'h1c000018, 2'd1); tick();
    look(32'h1c000134, beq_f, 1'b0); lit("beq_spec_ghr", 1'b1, 32'h1c000154, 2'd1); tick();
    clr();

    // Call/return pairing
    look(32'h1c000200, mk26(OP_BL, 32'sh100), 1'b1); lit("bl", 1'b1, 32'h1c000300, 2'd1); tick();
    look(32'h1c000210, ret_i, 1'b1); lit("ret_ras", 1'b1, 32'h1c000204, 2'd2); tick();
    look(32'h1c000214, ret_i, 1'b1); lit("ret_empty", 1'b0, 32'h0, 2'd0); tick();
    clr();

    // RAS overflow: 9 calls, newest 8 pop in LIFO order
    for (int i = 0; i < 9; i++) begin
      look(32'h1c001000 + 32'(16 * i), mk26(OP_BL, 32'sh40), 1'b1); tick();
    end
    for (int i = 8; i >= 1; i--) begin
      look(32'h1c001800, ret_i, 1'b1); lit("ras_lifo", 1'b1, 32'h1c001004 + 32'(16 * i), 2'd2); tick();
    end
    look(32'h1c001800, ret_i, 1'b1); lit("ras_drained", 1'b0, 32'h0, 2'd0); tick();
    clr();

    // BTB allocate, round-robin replacement, update in place
    retire(32'h1c000300, jr5, 1'b1, 32'h1c008000); tick(); clr();
    look(32'h1c000300, jr5, 1'b0); lit("btb_hit", 1'b1, 32'h1c008000, 2'd3); tick(); clr();
    for (int i = 0; i < 16; i++) begin
      retire(32'h1c000400 + 32'(4 * i), jr5, 1'b1, 32'h1c009000 + 32'(16 * i)); tick();
    end
    clr();
    look(32'h1c000300, jr5, 1'b0); lit("btb_evict", 1'b0, 32'h0, 2'd0); tick();
    look(32'h1c00043c, jr5, 1'b0); lit("btb_last", 1'b1, 32'h1c0090f0, 2'd3); tick();
    clr();
    retire(32'h1c000404, jr5, 1'b1, 32'h1c00a000); tick(); clr();
    look(32'h1c000404, jr5, 1'b0); lit("btb_overwrite", 1'b1, 32'h1c00a000, 2'd3); tick();
    look(32'h1c000400, jr5, 1'b0); lit("btb_no_alloc", 1'b1, 32'h1c009000, 2'd3); tick();
    clr();

    // Flush restores committed RAS
    for (int i = 0; i < 3; i++) begin
      look(32'h1c002000 + 32'(16 * i), mk26(OP_BL, 32'sh40), 1'b1); tick();
    end
    clr(); retire(32'h1c002000, mk26(OP_BL, 32'sh40), 1'b1, 32'h1c002040); tick();
    clr(); flush = 1'b1; tick(); clr();
    look(32'h1c003000, ret_i, 1'b1); lit("flush_top", 1'b1, 32'h1c002004, 2'd2); tick();
    look(32'h1c003000, ret_i, 1'b1); lit("flush_cnt1", 1'b0, 32'h0, 2'd0); tick();
    clr();

    // Flush coincident with a retiring call; accepted lookup is overridden
    look(32'h1c002050, mk26(OP_BL, 32'sh40), 1'b1); tick();
    retire(32'h1c002010, mk26(OP_BL, 32'sh40), 1'b1, 32'h1c002050);
    flush = 1'b1;
    look(32'h1c002060, mk26(OP_BL, 32'sh40), 1'b1);
    lit("flush_cycle_out", 1'b1, 32'h1c0020a0, 2'd1);
    tick(); clr();
    look(32'h1c003000, ret_i, 1'b1); lit("flush_upd_top", 1'b1, 32'h1c002014, 2'd2); tick();
    look(32'h1c003000, ret_i, 1'b1); lit("flush_upd_2nd", 1'b1, 32'h1c002004, 2'd2); tick();
    look(32'h1c003000, ret_i, 1'b1); lit("flush_upd_cnt2", 1'b0, 32'h0, 2'd0); tick();
    clr();

    // Reset mid-operation beats update, accept and flush
    look(32'h1c004000, mk26(OP_BL, 32'sh40), 1'b1);
    retire(32'h1c004000, mk26(OP_BL, 32'sh40), 1'b1, 32'h1c004040);
    flush = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; clr();
    look(32'h1c003000, ret_i, 1'b0); lit("rst_ras", 1'b0, 32'h0, 2'd0); tick();
    look(32'h1c000100, beq_f, 1'b0); lit("rst_pht", 1'b0, 32'h0, 2'd0); tick();
    look(32'h1c000404, jr5, 1'b0);   lit("rst_btb", 1'b0, 32'h0, 2'd0); tick();
    look(32'h1c000000, mk26(OP_B, 32'sh40), 1'b0); lit("rst_b", 1'b1, 32'h1c000040, 2'd1); tick();
    clr();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
